// File: rtl/condiciona_botoes_if.sv
// Button-conditioner bus: raw switch inputs toward the block, step pulses and
// lockout status back toward the temperature controller.
interface condiciona_botoes_if;
   logic       btn_up;
   logic       btn_down;
   logic       aumentar;
   logic       diminuir;
   logic       bloqueado;
   logic [1:0] estado;

   modport master (
      output btn_up,
      output btn_down,
      input  aumentar,
      input  diminuir,
      input  bloqueado,
      input  estado
   );

   modport slave (
      input  btn_up,
      input  btn_down,
      output aumentar,
      output diminuir,
      output bloqueado,
      output estado
   );
endinterface

// File: rtl/condiciona_botoes.sv
// Conditions two raw temperature buttons into step pulses: synchronize, debounce,
// then an FSM issues an initial pulse, a hold delay and auto-repeat, with lockout.
module condiciona_botoes #(
   parameter int NUM_DEBOUNCE   = 3,
   parameter int NUM_HOLD_DELAY = 6,
   parameter int NUM_REPEAT     = 2
) (
   input  logic                clk_2,
   input  logic                reset,
   condiciona_botoes_if.slave  bus
);

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      ESPERA   = 2'd1,
      REPETE   = 2'd2,
      BLOQUEIO = 2'd3
   } state_t;

   localparam logic [2:0] DB_LAST   = 3'(NUM_DEBOUNCE - 1);
   localparam logic [3:0] HOLD_LAST = 4'(NUM_HOLD_DELAY - 1);
   localparam logic [3:0] REP_LAST  = 4'(NUM_REPEAT - 1);

   // Channel 0 is "up", channel 1 is "down" throughout.
   logic [1:0] raw;
   logic [1:0] sync_p0;
   logic [1:0] sync_p1;
   logic [1:0] db;
   logic [2:0] db_cnt [2];

   state_t     state;
   logic [3:0] hold;
   logic       dir_up;
   logic       up_pulse;
   logic       down_pulse;
   logic       lock;

   logic       active;
   logic       other;
   logic [3:0] hold_last;

   assign raw = {bus.btn_down, bus.btn_up};

   // Stage p0/p1: two-flop synchronizer per channel.
   always_ff @(posedge clk_2) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
      end
   end

   // Debounce: the level flips only after NUM_DEBOUNCE consecutive differing samples.
   always_ff @(posedge clk_2) begin
      if (reset) begin
         db        <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync_p1[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db[i]     <= ~db[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 3'd1;
            end
         end
      end
   end

   assign active    = dir_up ? db[0] : db[1];
   assign other     = dir_up ? db[1] : db[0];
   assign hold_last = (state == ESPERA) ? HOLD_LAST : REP_LAST;

   // Press/hold/repeat FSM; all outputs registered alongside the state.
   always_ff @(posedge clk_2) begin
      if (reset) begin
         state      <= OCIOSO;
         hold       <= '0;
         dir_up     <= 1'b0;
         up_pulse   <= 1'b0;
         down_pulse <= 1'b0;
         lock       <= 1'b0;
      end else begin
         up_pulse   <= 1'b0;
         down_pulse <= 1'b0;
         case (state)
            OCIOSO: begin
               hold <= '0;
               if (db[0] && db[1]) begin
                  state <= BLOQUEIO;
                  lock  <= 1'b1;
               end else if (db[0]) begin
                  state    <= ESPERA;
                  dir_up   <= 1'b1;
                  up_pulse <= 1'b1;
               end else if (db[1]) begin
                  state      <= ESPERA;
                  dir_up     <= 1'b0;
                  down_pulse <= 1'b1;
               end
            end
            ESPERA, REPETE: begin
               // The opposite button wins over everything, then release, then timing.
               if (other) begin
                  state <= BLOQUEIO;
                  lock  <= 1'b1;
                  hold  <= '0;
               end else if (!active) begin
                  state <= OCIOSO;
                  hold  <= '0;
               end else if (hold == hold_last) begin
                  state      <= REPETE;
                  hold       <= '0;
                  up_pulse   <= dir_up;
                  down_pulse <= ~dir_up;
               end else begin
                  hold <= hold + 4'd1;
               end
            end
            BLOQUEIO: begin
               hold <= '0;
               if (!db[0] && !db[1]) begin
                  state <= OCIOSO;
                  lock  <= 1'b0;
               end
            end
            default: begin
               state <= OCIOSO;
               hold  <= '0;
               lock  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.aumentar  = up_pulse;
   assign bus.diminuir  = down_pulse;
   assign bus.bloqueado = lock;
   assign bus.estado    = state;

endmodule

// File: tb/tb_condiciona_botoes.sv
// Directed per-cycle vector tables for condiciona_botoes at default parameters,
// followed by random button activity with per-cycle invariant checks.
module tb_condiciona_botoes;

   logic clk_2;
   logic reset;

   condiciona_botoes_if bus ();

   condiciona_botoes #(
      .NUM_DEBOUNCE   (3),
      .NUM_HOLD_DELAY (6),
      .NUM_REPEAT     (2)
   ) dut (
      .clk_2 (clk_2),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk_2 = 1'b0;
   always #5 clk_2 = ~clk_2;

   typedef struct {
      logic       rst;
      logic       up;
      logic       dn;
      logic       aum;
      logic       dim;
      logic [1:0] est;
      string      tag;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic string strip(string s);
      string o = "";
      for (int i = 0; i < s.len(); i++)
         if (s[i] != "_") o = {o, s.substr(i, i)};
      return o;
   endfunction

   // One character per clock edge; row k is driven before edge k and checked after it.
   function automatic void add(string tag, string rs, string up, string dn,
                               string au, string di, string es);
      string r = strip(rs), u = strip(up), d = strip(dn);
      string a = strip(au), m = strip(di), e = strip(es);
      if (r.len() != u.len() || d.len() != u.len() || a.len() != u.len() ||
          m.len() != u.len() || e.len() != u.len()) begin
         $display("FAIL table_%s: row strings have unequal lengths", tag);
         n_bad++;
         return;
      end
      for (int i = 0; i < u.len(); i++) begin
         vec_t v;
         v.rst = (r[i] == "1");
         v.up  = (u[i] == "1");
         v.dn  = (d[i] == "1");
         v.aum = (a[i] == "1");
         v.dim = (m[i] == "1");
         v.est = 2'(r[i] == "x" ? 0 : (e[i] - 8'd48));
         v.tag = $sformatf("%s[%0d]", tag, i + 1);
         vecs.push_back(v);
      end
   endfunction

   task automatic check_vec(vec_t v);
      logic [4:0] got, exp;
      got = {bus.aumentar, bus.diminuir, bus.bloqueado, bus.estado};
      exp = {v.aum, v.dim, (v.est == 2'd3), v.est};
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got aum=%b dim=%b blq=%b est=%0d, want aum=%b dim=%b blq=%b est=%0d",
                  v.tag, got[4], got[3], got[2], got[1:0], exp[4], exp[3], exp[2], exp[1:0]);
      end
   endtask

   task automatic check_inv(int cyc);
      n_vec++;
      if ((bus.aumentar & bus.diminuir) !== 1'b0) begin
         n_bad++;
         $display("FAIL rnd_exclusive[%0d]: got aum=%b dim=%b, want not both high",
                  cyc, bus.aumentar, bus.diminuir);
      end
      n_vec++;
      if (bus.bloqueado !== (bus.estado == 2'd3)) begin
         n_bad++;
         $display("FAIL rnd_blq[%0d]: got blq=%b est=%0d, want blq=%b",
                  cyc, bus.bloqueado, bus.estado, (bus.estado == 2'd3));
      end
   endtask

   initial begin
      reset      = 1'b1;
      bus.btn_up = 1'b0;
      bus.btn_down = 1'b0;

      // Reset state.
      add("reset", "11", "00", "00", "00", "00", "00");
      // Hold up 20 cycles: pulses at 6,12,14..20, plus 22,24 while the release debounces.
      add("hold_up",
          "0000000000_0000000000_0000000000",
          "1111111111_1111111111_0000000000",
          "0000000000_0000000000_0000000000",
          "0000010000_0101010101_0101000000",
          "0000000000_0000000000_0000000000",
          "0000011111_1222222222_2222200000");
      // Two-cycle glitch on down: filtered out.
      add("glitch_dn",
          "000000000000", "000000000000", "110000000000",
          "000000000000", "000000000000", "000000000000");
      // Three-cycle press on up: just long enough for one pulse.
      add("short_up",
          "000000000000", "111000000000", "000000000000",
          "000001000000", "000000000000", "000001110000");
      // Both pressed: lockout; release up only stays locked; release both unlocks.
      add("both",
          "0000000000_0000000000_0000000000",
          "1111111111_0000000000_0000000000",
          "1111111111_1111111111_0000000000",
          "0000000000_0000000000_0000000000",
          "0000000000_0000000000_0000000000",
          "0000033333_3333333333_3333300000");
      // Down repeating, then up pressed: repeat stops, lockout, no up pulse.
      add("dn_then_up",
          "0000000000_0000000000_0000000000_00",
          "0000000000_0000111111_1111000000_00",
          "1111111111_1111111111_1111000000_00",
          "0000000000_0000000000_0000000000_00",
          "0000010000_0101010100_0000000000_00",
          "0000011111_1222222223_3333333330_00");
      // Reset mid-repeat with up held; held button re-presses after full latency,
      // release just before the hold delay expires gives no pulse.
      add("rst_repeat",
          "0000000000_0000010000_0000000000",
          "1111111111_1111111111_1100000000",
          "0000000000_0000000000_0000000000",
          "0000010000_0101000000_0100000000",
          "0000000000_0000000000_0000000000",
          "0000011111_1222200000_0111111000");

      foreach (vecs[k]) begin
         reset        = vecs[k].rst;
         bus.btn_up   = vecs[k].up;
         bus.btn_down = vecs[k].dn;
         @(posedge clk_2);
         #1;
         check_vec(vecs[k]);
      end

      // Random activity with occasional resets; invariants checked every cycle.
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 7) == 0) bus.btn_up   = ~bus.btn_up;
         if ($urandom_range(0, 7) == 0) bus.btn_down = ~bus.btn_down;
         reset = ($urandom_range(0, 99) == 0);
         @(posedge clk_2);
         #1;
         check_inv(c);
      end

      reset        = 1'b1;
      bus.btn_up   = 1'b0;
      bus.btn_down = 1'b0;
      @(posedge clk_2);
      #1;
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
